// File: rtl/iiitb_sdm_pkg.sv
// Shared constants for the 1010 sync-word link: sync word, stuff trigger, state encoding.
// Imported by the transmitter, its stuffer and the receiver side.
package iiitb_sdm_pkg;

    localparam logic [3:0] SYNC_WORD  = 4'b1010;
    localparam int         SYNC_LEN   = 4;
    localparam logic [2:0] STUFF_TRIG = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Sync bits go out MSB first, so index 0 is SYNC_WORD[SYNC_LEN-1].
    function automatic logic sync_bit(input logic [1:0] idx);
        logic [1:0] pos;
        pos = 2'(SYNC_LEN - 1) - idx;
        return SYNC_WORD[pos];
    endfunction

endpackage

// File: rtl/iiitb_sdm_tx_if.sv
// Payload valid/ready handshake into the sync-word transmitter.
interface iiitb_sdm_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/iiitb_sdm_stuffer.sv
// Line history (last three bits driven, oldest in bit 2) and the stuff request it implies.
// Shared with the receiver's de-stuffer, which feeds it the received bits instead.
module iiitb_sdm_stuffer
    import iiitb_sdm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_i,
    output logic stuff_req_o
);

    logic [2:0] hist_q;
    logic [2:0] hist_d;

    assign hist_d = {hist_q[1:0], bit_i};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign stuff_req_o = (hist_q == STUFF_TRIG);

endmodule

// File: rtl/iiitb_sdm_tx.sv
// Serial frame transmitter: sync word 1010, bit-stuffed MSB-first payload, zero gap.
// state_q always names the kind of bit currently on dout; the comb block picks the next bit.
module iiitb_sdm_tx
    import iiitb_sdm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic           clk,
    input  logic           reset,
    iiitb_sdm_tx_if.slave  din_if,
    output logic           dout,
    output logic           sync_mark,
    output logic           busy
);

    localparam int MAX_CNT = (DATA_W > GAP_BITS)
                           ? ((DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN)
                           : ((GAP_BITS > SYNC_LEN) ? GAP_BITS : SYNC_LEN);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, left;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                dout_d, mark_d;
    logic                stuff_req, accept, data_step;

    assign din_if.din_ready = reset & (state_q == IDLE);
    assign accept           = din_if.din_valid & din_if.din_ready;
    assign busy             = (state_q != IDLE);

    iiitb_sdm_stuffer u_stuffer (
        .clk         (clk),
        .reset       (reset),
        .bit_i       (dout_d),
        .stuff_req_o (stuff_req)
    );

    // cnt_q counts sync bits sent in SYNC, payload bits left in DATA, gap bits sent in GAP.
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        dout_d    = 1'b0;
        mark_d    = 1'b0;
        data_step = 1'b0;
        left      = (state_q == SYNC) ? CNT_W'(DATA_W) : cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SYNC;
                    dout_d  = sync_bit(2'd0);
                    cnt_d   = CNT_W'(1);
                    shreg_d = din_if.din;
                end
            end
            SYNC: begin
                if (cnt_q != CNT_W'(SYNC_LEN)) begin
                    dout_d = sync_bit(cnt_q[1:0]);
                    mark_d = (cnt_q == CNT_W'(SYNC_LEN - 1));
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    data_step = 1'b1;
                end
            end
            DATA: data_step = 1'b1;
            GAP: begin
                if (cnt_q != CNT_W'(GAP_BITS)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stuff request also covers the tail stuff once the payload is exhausted.
        if (data_step) begin
            state_d = DATA;
            if (stuff_req) begin
                dout_d = 1'b1;
                cnt_d  = left;
            end else if (left != '0) begin
                dout_d  = shreg_q[DATA_W-1];
                shreg_d = shreg_q << 1;
                cnt_d   = left - CNT_W'(1);
            end else begin
                state_d = GAP;
                cnt_d   = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            dout      <= 1'b0;
            sync_mark <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            dout      <= dout_d;
            sync_mark <= mark_d;
        end
    end

endmodule

// File: tb/tb_iiitb_sdm_tx.sv
// Self-checking bench for iiitb_sdm_tx: directed frame table, back-to-back, mid-frame reset,
// random payloads recovered by a de-stuffing scoreboard, and a 1010 line monitor.
module tb_iiitb_sdm_tx;
    import iiitb_sdm_pkg::*;

    localparam int DATA_W   = 8;
    localparam int GAP_BITS = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic dout, sync_mark, busy;

    iiitb_sdm_tx_if #(.DATA_W(DATA_W)) din_if ();

    iiitb_sdm_tx #(.DATA_W(DATA_W), .GAP_BITS(GAP_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .din_if    (din_if.slave),
        .dout      (dout),
        .sync_mark (sync_mark),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int frames    = 0;

    // Reference overlapping 1010 detector watching the line.
    logic [3:0] mon_sh = 4'b0000;
    int det_cnt  = 0;
    int bad_det  = 0;
    int mark_cnt = 0;
    always @(negedge clk) begin
        mon_sh = {mon_sh[2:0], dout};
        if (mon_sh == 4'b1010) begin
            det_cnt++;
            if (!sync_mark) bad_det++;
        end
        if (sync_mark) mark_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Offers one payload, then captures dout every cycle until din_ready returns (bounded).
    task automatic send_frame(input logic [7:0] payload, output logic [63:0] line,
                              output int len, output int mark_pos);
        line     = '0;
        len      = 0;
        mark_pos = -1;
        @(negedge clk);
        din_if.din       = payload;
        din_if.din_valid = 1'b1;
        check("accept_ready", din_if.din_ready, 1);
        @(posedge clk);
        #1;
        din_if.din_valid = 1'b0;
        din_if.din       = ~payload;
        frames++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (din_if.din_ready) break;
            line = {line[62:0], dout};
            if (sync_mark) mark_pos = len;
            len++;
        end
    endtask

    // Independent de-stuffer: checks sync, stuff bits, tail stuff and gap; recovers payload.
    function automatic logic destuff(input logic [63:0] line, input int len, output logic [7:0] data);
        logic [2:0] h;
        logic       ok;
        logic       b;
        int         n;
        h    = 3'b000;
        ok   = 1'b1;
        n    = 0;
        data = '0;
        if (len < SYNC_LEN + DATA_W + GAP_BITS || len > 63) return 1'b0;
        for (int k = 0; k < len; k++) begin
            b = line[len-1-k];
            if (k < SYNC_LEN) begin
                if (b != SYNC_WORD[SYNC_LEN-1-k]) ok = 1'b0;
            end else if (k >= len - GAP_BITS) begin
                if (b) ok = 1'b0;
                if (k == len - GAP_BITS && h == 3'b101) ok = 1'b0;
            end else if (h == 3'b101) begin
                if (!b) ok = 1'b0;
            end else begin
                if (n < DATA_W) data = {data[6:0], b};
                n++;
            end
            h = {h[1:0], b};
        end
        return ok && (n == DATA_W);
    endfunction

    typedef struct {
        logic [7:0]  payload;
        int          len;
        logic [31:0] line;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] line;
    int          len, mark_pos, d0;
    logic [7:0]  rec, pl;

    initial begin
        vecs[0] = '{8'h00, 14, 32'b1010_00000000_00};
        vecs[1] = '{8'hFF, 15, 32'b1010_111111111_00};
        vecs[2] = '{8'hA5, 17, 32'b1010_11011001011_00};
        vecs[3] = '{8'h5A, 16, 32'b1010_0101110110_00};
        vecs[4] = '{8'h3C, 14, 32'b1010_00111100_00};
        vecs[5] = '{8'h55, 17, 32'b1010_01011011011_00};

        // Reset state, with a payload offered that must not be taken.
        din_if.din       = 8'hFF;
        din_if.din_valid = 1'b1;
        #12;
        check("rst_dout", dout, 0);
        check("rst_mark", sync_mark, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", din_if.din_ready, 0);
        @(negedge clk);
        reset            = 1'b1;
        din_if.din_valid = 1'b0;
        #1;
        check("post_rst_ready", din_if.din_ready, 1);
        check("post_rst_dout", dout, 0);

        foreach (vecs[i]) begin
            d0 = det_cnt;
            send_frame(vecs[i].payload, line, len, mark_pos);
            #1;
            check($sformatf("len_%02h", vecs[i].payload), len, vecs[i].len);
            check($sformatf("line_%02h", vecs[i].payload), line, {32'b0, vecs[i].line});
            check($sformatf("mark_%02h", vecs[i].payload), mark_pos, 3);
            check($sformatf("det_%02h", vecs[i].payload), det_cnt - d0, 1);
            check($sformatf("idle_busy_%02h", vecs[i].payload), busy, 0);
        end

        // Back-to-back A5 then 5A with din_valid held: one idle cycle between frames.
        d0 = det_cnt;
        @(negedge clk);
        din_if.din       = 8'hA5;
        din_if.din_valid = 1'b1;
        check("b2b_accept_ready", din_if.din_ready, 1);
        @(posedge clk);
        #1;
        din_if.din = 8'h5A;
        frames += 2;
        line = '0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 17) check("b2b_gap_ready", din_if.din_ready, 0);
            if (k == 18) check("b2b_idle_ready", din_if.din_ready, 1);
            if (k == 19) din_if.din_valid = 1'b0;
            line = {line[62:0], dout};
        end
        #1;
        check("b2b_line", line, {30'b0, 17'b1010_11011001011_00, 1'b0, 16'b1010_0101110110_00});
        check("b2b_det", det_cnt - d0, 2);

        // Reset in the 6th DATA cycle of an FF frame, then a clean 3C frame.
        @(negedge clk);
        din_if.din       = 8'hFF;
        din_if.din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_if.din_valid = 1'b0;
        frames++;
        repeat (10) @(negedge clk);
        check("mid_pre_dout", dout, 1);
        check("mid_pre_busy", busy, 1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_dout", dout, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", din_if.din_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_ready", din_if.din_ready, 1);
        d0 = det_cnt;
        send_frame(8'h3C, line, len, mark_pos);
        #1;
        check("mid_3c_line", line, {50'b0, 14'b1010_00111100_00});
        check("mid_3c_det", det_cnt - d0, 1);

        // Random payloads with random idle gaps, recovered by the de-stuffer.
        for (int f = 0; f < 400; f++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pl = 8'($urandom);
            send_frame(pl, line, len, mark_pos);
            if (!destuff(line, len, rec)) rec = ~pl;
            check($sformatf("rand_%0d_%02h", f, pl), rec, pl);
        end

        repeat (3) @(negedge clk);
        #1;
        check("no_stray_1010", bad_det, 0);
        check("det_eq_marks", det_cnt, mark_cnt);
        check("det_eq_frames", det_cnt, frames);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
